// File: rtl/spi_move_receiver.sv
// spi_move_receiver: SPI-slave (mode 0) move receiver for Connect 4.
// The SPI pins are oversampled in the clk domain. MSB-first frames are
// deframed, range-checked as column indices, and buffered in a small FIFO.
// The FIFO drains through a valid/ready handshake.
// Optional feature: define PARITY_CHECK_EN to append one even-parity bit
// to each frame and reject frames whose parity does not match.
module spi_move_receiver #(
   parameter int DATA_W      = 8,
   parameter int NUM_COLS    = 7,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            spi_clk,
   input  logic                            spi_mosi,
   input  logic                            spi_cs,
   input  logic                            move_ready,
   output logic                            move_valid,
   output logic [$clog2(NUM_COLS)-1:0]     move_col,
   output logic                            frame_err,
   output logic                            overflow,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

   localparam int COL_W = $clog2(NUM_COLS);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
`ifdef PARITY_CHECK_EN
   localparam int FRAME_W = DATA_W + 1;
`else
   localparam int FRAME_W = DATA_W;
`endif
   localparam int BIT_W = $clog2(FRAME_W + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2,
      WAIT  = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Synchronisers and edge detection
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic                   sclk_prev;
   logic                   cs_prev;
   logic                   sclk_s;
   logic                   mosi_s;
   logic                   cs_s;
   logic                   sclk_rise;
   logic                   cs_fall;
   logic                   cs_rise;

   // Bring the SPI pins into the clk domain; cs idles high, the rest low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         cs_sync   <= '1;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
         sclk_prev <= sclk_s;
         cs_prev   <= cs_s;
      end
   end

   // mosi travels through the same number of stages as spi_clk, so the
   // synchronised data bit lines up with the detected clock rise.
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev;
   assign cs_fall   = ~cs_s & cs_prev;
   assign cs_rise   = cs_s & ~cs_prev;

   // ------------------------------------------------------------------
   // Deframing FSM and datapath
   // ------------------------------------------------------------------
   state_t               state_reg;
   state_t               state_next;
   logic [FRAME_W-1:0]   shift_reg;
   logic [BIT_W-1:0]     bit_cnt_reg;
   logic                 extra_reg;
   logic [DATA_W-1:0]    word;
   logic                 parity_bad;
   logic                 out_of_range;
   logic                 last_bit;

   logic                 push;
   logic                 pop;
   logic                 fifo_full;
   logic                 frame_err_next;
   logic                 overflow_next;

   assign word         = shift_reg[FRAME_W-1 -: DATA_W];
   assign out_of_range = (word >= DATA_W'(NUM_COLS));
   assign last_bit     = (bit_cnt_reg == BIT_W'(FRAME_W - 1));
`ifdef PARITY_CHECK_EN
   // Data plus even-parity bit must XOR to zero.
   assign parity_bad   = ^shift_reg;
`else
   assign parity_bad   = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; a cs rise always wins over a simultaneous clock rise.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (cs_fall) state_next = SHIFT;
         end
         SHIFT: begin
            if (cs_rise) begin
               state_next = IDLE;
            end else if (sclk_rise && last_bit) begin
               state_next = CHECK;
            end
         end
         CHECK: begin
            // A cs rise landing in the single CHECK cycle must not be lost.
            state_next = cs_rise ? IDLE : WAIT;
         end
         WAIT: begin
            if (cs_rise) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Output decode: error/overflow pulses and the FIFO push strobe.
   always_comb begin
      frame_err_next = 1'b0;
      overflow_next  = 1'b0;
      push           = 1'b0;
      case (state_reg)
         SHIFT: begin
            if (cs_rise) frame_err_next = 1'b1;
         end
         CHECK: begin
            if (parity_bad || out_of_range) begin
               frame_err_next = 1'b1;
            end else if (fifo_full && !pop) begin
               overflow_next = 1'b1;
            end else begin
               push = 1'b1;
            end
         end
         WAIT: begin
            if (cs_rise && extra_reg) frame_err_next = 1'b1;
         end
         default: ;
      endcase
   end

   // Shift register, bit counter and the extra-clock flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
         extra_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (cs_fall) begin
                  shift_reg   <= '0;
                  bit_cnt_reg <= '0;
                  extra_reg   <= 1'b0;
               end
            end
            SHIFT: begin
               if (sclk_rise && !cs_rise) begin
                  shift_reg   <= {shift_reg[FRAME_W-2:0], mosi_s};
                  bit_cnt_reg <= bit_cnt_reg + 1'b1;
               end
            end
            CHECK, WAIT: begin
               if (sclk_rise) extra_reg <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Error and overflow pulses are registered so they are glitch-free.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         frame_err <= frame_err_next;
         overflow  <= overflow_next;
      end
   end

   // ------------------------------------------------------------------
   // Move FIFO
   // ------------------------------------------------------------------
   logic [COL_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;

   assign fifo_full = (count_reg == CNT_W'(FIFO_DEPTH));
   assign pop       = (count_reg != '0) && move_ready;

   // Storage write; the head is read directly so move_col holds steady.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= word[COL_W-1:0];
   end

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign move_valid = (count_reg != '0);
   assign move_col   = move_valid ? mem[rd_ptr_reg] : '0;
   assign fifo_count = count_reg;

endmodule

// File: tb/tb_spi_move_receiver.sv
// tb_spi_move_receiver: scoreboard bench for spi_move_receiver.
// Stimulus predicts each frame's outcome from the frame rules and queues
// the expected moves; a monitor pops and compares on every handshake.
module tb_spi_move_receiver;

   localparam int DATA_W      = 8;
   localparam int NUM_COLS    = 7;
   localparam int FIFO_DEPTH  = 4;
   localparam int SYNC_STAGES = 2;
   localparam int COL_W       = $clog2(NUM_COLS);
   localparam int HALF        = 4;
`ifdef PARITY_CHECK_EN
   localparam int FW = DATA_W + 1;
`else
   localparam int FW = DATA_W;
`endif

   logic                         clk = 1'b0;
   logic                         rst = 1'b0;
   logic                         spi_clk = 1'b0;
   logic                         spi_mosi = 1'b0;
   logic                         spi_cs = 1'b1;
   logic                         move_ready = 1'b0;
   logic                         move_valid;
   logic [COL_W-1:0]             move_col;
   logic                         frame_err;
   logic                         overflow;
   logic [$clog2(FIFO_DEPTH):0]  fifo_count;

   spi_move_receiver #(
      .DATA_W(DATA_W), .NUM_COLS(NUM_COLS),
      .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
      .spi_cs(spi_cs), .move_ready(move_ready), .move_valid(move_valid),
      .move_col(move_col), .frame_err(frame_err), .overflow(overflow),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Written by stimulus only.
   logic [COL_W-1:0] exp_q[$];
   int err_exp = 0;
   int ovf_exp = 0;
   int q_seq = 0;
   int lat_seq = 0;
   int last_rise_cyc = 0;

   // Written by monitor only.
   int checks = 0;
   int failures = 0;
   int pop_idx = 0;
   int err_seen = 0;
   int ovf_seen = 0;
   int q_done = 0;
   int lat_done = 0;
   logic prev_valid = 1'b0;
   logic prev_ready = 1'b0;
   logic [COL_W-1:0] prev_col = '0;

   // Monitor: handshakes, pulse counting, latency and quiescent checks.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            pop_idx    = exp_q.size();
            prev_valid = 1'b0;
         end else begin
            if (frame_err) err_seen++;
            if (overflow)  ovf_seen++;
            if (frame_err || overflow) begin
               checks++;
               if (frame_err && overflow) begin
                  failures++;
                  $display("FAIL pulse_exclusive: frame_err=%0b overflow=%0b, required not both", frame_err, overflow);
               end
            end
            if (prev_valid && !prev_ready && move_valid) begin
               checks++;
               if (move_col !== prev_col) begin
                  failures++;
                  $display("FAIL col_stable: move_col=%0d, required %0d", move_col, prev_col);
               end
            end
            if (lat_seq != lat_done && move_valid && !prev_valid) begin
               checks++;
               if (cyc - last_rise_cyc > SYNC_STAGES + 3) begin
                  failures++;
                  $display("FAIL latency: %0d cycles, required <= %0d", cyc - last_rise_cyc, SYNC_STAGES + 3);
               end
               lat_done = lat_seq;
            end
            if (move_valid && move_ready) begin
               checks++;
               if (pop_idx >= exp_q.size()) begin
                  failures++;
                  $display("FAIL pop_unexpected: move_col=%0d, required no move", move_col);
               end else begin
                  if (move_col !== exp_q[pop_idx]) begin
                     failures++;
                     $display("FAIL pop_col: move_col=%0d, required %0d", move_col, exp_q[pop_idx]);
                  end else begin
                     $display("pop col=%0d ok", move_col);
                  end
                  pop_idx++;
               end
            end
            if (q_seq != q_done) begin
               q_done = q_seq;
               checks += 5;
               if (fifo_count !== ($clog2(FIFO_DEPTH)+1)'(exp_q.size() - pop_idx)) begin
                  failures++;
                  $display("FAIL fifo_count: got %0d, required %0d", fifo_count, exp_q.size() - pop_idx);
               end
               if (move_valid !== (exp_q.size() > pop_idx)) begin
                  failures++;
                  $display("FAIL move_valid: got %0b, required %0b", move_valid, exp_q.size() > pop_idx);
               end
               if (err_seen != err_exp) begin
                  failures++;
                  $display("FAIL frame_err_count: got %0d, required %0d", err_seen, err_exp);
               end
               if (ovf_seen != ovf_exp) begin
                  failures++;
                  $display("FAIL overflow_count: got %0d, required %0d", ovf_seen, ovf_exp);
               end
               if (frame_err !== 1'b0 || overflow !== 1'b0) begin
                  failures++;
                  $display("FAIL idle_pulses: frame_err=%0b overflow=%0b, required 0 0", frame_err, overflow);
               end
               if (lat_seq != lat_done) begin
                  checks++;
                  failures++;
                  $display("FAIL latency_timeout: move_valid never rose, required within %0d cycles", SYNC_STAGES + 3);
                  lat_done = lat_seq;
               end
               $display("check #%0d count=%0d errs=%0d ovfs=%0d", q_done, fifo_count, err_seen, ovf_seen);
            end
            prev_valid = move_valid;
            prev_ready = move_ready;
            prev_col   = move_col;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Let the DUT settle, then ask the monitor for a quiescent check.
   task automatic quiesce();
      tick(12);
      q_seq++;
      tick(2);
   endtask

   // Drive one cs window: nbits bits MSB first, then extra clock pulses.
   task automatic spi_frame(input logic [15:0] bits, input int nbits, input int extra, input bit arm_lat);
      spi_cs = 1'b0;
      spi_mosi = (nbits > 0) ? bits[nbits-1] : 1'b0;
      tick(HALF);
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = bits[nbits-1-i];
         tick(HALF);
         spi_clk = 1'b1;
         if (arm_lat && i == nbits - 1) begin
            last_rise_cyc = cyc;
            lat_seq++;
         end
         tick(HALF);
         spi_clk = 1'b0;
      end
      for (int e = 0; e < extra; e++) begin
         spi_mosi = 1'($urandom);
         tick(HALF);
         spi_clk = 1'b1;
         tick(HALF);
         spi_clk = 1'b0;
      end
      tick(HALF);
      spi_cs = 1'b1;
      tick(HALF);
   endtask

   // Predict the outcome of a frame from the frame rules, then send it.
   task automatic send_move(input int word, input int nbits, input int extra, input bit bad_par, input bit arm_lat);
      logic [15:0] bits;
      logic [DATA_W-1:0] w;
      int occ;
      bit parity_wrong;
      w = DATA_W'(word);
`ifdef PARITY_CHECK_EN
      bits = {7'd0, w, (^w) ^ bad_par};
      parity_wrong = bad_par;
`else
      bits = {8'd0, w};
      parity_wrong = 1'b0;
`endif
      occ = exp_q.size() - pop_idx;
      if (nbits < FW) begin
         err_exp++;
      end else begin
         if (parity_wrong || word >= NUM_COLS) err_exp++;
         else if (!move_ready && occ >= FIFO_DEPTH) ovf_exp++;
         else exp_q.push_back(COL_W'(word));
         if (extra > 0) err_exp++;
      end
      $display("frame word=%0d bits=%0d extra=%0d badpar=%0b ready=%0b", word, nbits, extra, parity_wrong, move_ready);
      spi_frame(bits, nbits, extra, arm_lat);
      quiesce();
   endtask

   task automatic drain();
      move_ready = 1'b1;
      tick(FIFO_DEPTH + 4);
      move_ready = 1'b0;
      quiesce();
   endtask

   initial begin
      tick(5);
      rst = 1'b1;
      quiesce();

      // Single good move, latency, then one-cycle ready pulse.
      send_move(3, FW, 0, 1'b0, 1'b1);
      move_ready = 1'b1;
      tick(1);
      move_ready = 1'b0;
      quiesce();

      // Out of range, short frame, extra clocks after a good word.
      send_move(7, FW, 0, 1'b0, 1'b0);
      send_move(2, 5, 0, 1'b0, 1'b0);
      send_move(2, FW, 3, 1'b0, 1'b0);
      drain();

      // Fill to depth, overflow on the fifth, drain in order.
      for (int k = 0; k < 5; k++) send_move(k, FW, 0, 1'b0, 1'b0);
      drain();

`ifdef PARITY_CHECK_EN
      send_move(3, FW, 0, 1'b0, 1'b0);
      send_move(3, FW, 0, 1'b1, 1'b0);
      drain();
`endif

      // Randomised frames with random consumer readiness.
      for (int n = 0; n < 40; n++) begin
         int kind;
         int wd;
         move_ready = 1'($urandom_range(0, 2) == 0);
         kind = $urandom_range(0, 9);
         wd = (kind == 0) ? $urandom_range(0, 255) : $urandom_range(0, 8);
         if (kind == 1)      send_move(wd, $urandom_range(1, FW - 1), 0, 1'b0, 1'b0);
         else if (kind == 2) send_move(wd, FW, $urandom_range(1, 3), 1'b0, 1'b0);
`ifdef PARITY_CHECK_EN
         else if (kind == 3) send_move(wd, FW, 0, 1'b1, 1'b0);
`endif
         else                send_move(wd, FW, 0, 1'b0, 1'b0);
      end
      move_ready = 1'b0;
      quiesce();

      // Reset mid-frame with moves buffered: FIFO clears, no error pulse.
      send_move(1, FW, 0, 1'b0, 1'b0);
      send_move(4, FW, 0, 1'b0, 1'b0);
      spi_cs = 1'b0;
      tick(HALF);
      for (int i = 0; i < 3; i++) begin
         spi_mosi = 1'($urandom);
         tick(HALF);
         spi_clk = 1'b1;
         tick(HALF);
         spi_clk = 1'b0;
      end
      rst = 1'b0;
      spi_cs = 1'b1;
      tick(3);
      rst = 1'b1;
      quiesce();
      send_move(5, FW, 0, 1'b0, 1'b0);
      drain();

      tick(4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
